// File: rtl/multi_port_mem_ctrl.sv
// Round-robin arbiter of NUM_PORTS requesters onto a byte-serial RAM/IO bus with sign/zero-extending loads.
// Optional compressed-aware fetch mode (size 3) is enabled by defining MPMC_RVC_FETCH_EN.
module multi_port_mem_ctrl #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH = 4,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE = 'h30000,
   parameter logic [NUM_PORTS-1:0] FLUSH_MASK = '1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rdy,
   input  logic                            flush,
   input  logic                            io_buffer_full,
   input  logic [NUM_PORTS-1:0]            req_valid,
   output logic [NUM_PORTS-1:0]            req_ready,
   input  logic [NUM_PORTS-1:0]            req_write,
   input  logic [2*NUM_PORTS-1:0]          req_size,
   input  logic [NUM_PORTS-1:0]            req_unsigned,
   input  logic [ADDR_WIDTH*NUM_PORTS-1:0] req_addr,
   input  logic [DATA_WIDTH*NUM_PORTS-1:0] req_wdata,
   input  logic [ID_WIDTH*NUM_PORTS-1:0]   req_id,
   output logic [NUM_PORTS-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]           resp_data,
   output logic [ID_WIDTH-1:0]             resp_id,
   output logic                            busy,
   input  logic [7:0]                      ram_din,
   output logic [7:0]                      ram_dout,
   output logic [ADDR_WIDTH-1:0]           ram_addr,
   output logic                            ram_wr
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int CW = $clog2(NB) + 1;
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {IDLE, XFER, IO_WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         rr_q, rr_d, port_q, port_d, gnt_port;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr, io_off;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_q, data_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  write_q, write_d, uns_q, uns_d;
   logic [CW-1:0]         len_q, len_d, cnt_q, cnt_d, iss_idx_q;
   logic                  iss_vld_q;
   logic [1:0]            sel_size;
   logic [NUM_PORTS-1:0]  elig;
   logic                  gnt_found, accept, abort, issue;
`ifdef MPMC_RVC_FETCH_EN
   logic                  fetch_q, fetch_d;
`endif

   function automatic logic [CW-1:0] size_len(input logic [1:0] s);
      case (s)
         2'd0:    return CW'(1);
         2'd1:    return (NB >= 2) ? CW'(2) : CW'(NB);
         default: return CW'(NB);
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [CW-1:0] n, input logic u);
      logic [DATA_WIDTH-1:0] r;
      logic                  s;
      r = '0;
      s = 1'b0;
      for (int b = 0; b < NB; b++)
         if (CW'(b + 1) == n) s = d[8*b+7];
      for (int b = 0; b < NB; b++)
         r[8*b +: 8] = (CW'(b) < n) ? d[8*b +: 8] : {8{s & ~u}};
      return r;
   endfunction

   // A flushing masked port may still be granted, but only for stores.
   assign elig     = req_valid & ~({NUM_PORTS{flush}} & FLUSH_MASK & ~req_write);
   assign sel_addr = req_addr[int'(gnt_port)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_size = req_size[2*int'(gnt_port) +: 2];
   assign io_off   = sel_addr - IO_BASE;

   always_comb begin
      gnt_found = 1'b0;
      gnt_port  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!gnt_found && elig[(int'(rr_q) + k) % NUM_PORTS]) begin
            gnt_found = 1'b1;
            gnt_port  = PW'((int'(rr_q) + k) % NUM_PORTS);
         end
      end
   end

   assign accept    = gnt_found & rdy & ((state_q == IDLE) | (state_q == RESP));
   assign req_ready = accept ? (NUM_PORTS'(1) << gnt_port) : '0;
   assign abort     = flush & FLUSH_MASK[port_q] & ~write_q & ((state_q == XFER) | (state_q == IO_WAIT));
   assign issue     = (state_q == XFER) & (cnt_q < len_q) & ~abort;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      port_d  = port_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      id_d    = id_q;
      write_d = write_q;
      uns_d   = uns_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
`ifdef MPMC_RVC_FETCH_EN
      fetch_d = fetch_q;
`endif
      case (state_q)
         XFER: begin
            if (abort) state_d = IDLE;
            else begin
               if (issue) cnt_d = cnt_q + 1'b1;
               // Loads need one extra cycle for the last byte to come back.
               if (write_q ? (cnt_q == len_q - 1'b1) : (cnt_q == len_q)) state_d = RESP;
            end
         end
         IO_WAIT: begin
            if (abort) state_d = IDLE;
            else if (!io_buffer_full) state_d = XFER;
         end
         RESP:    state_d = IDLE;
         default: ;
      endcase
      if (accept) begin
         state_d = (io_off < ADDR_WIDTH'(8) && io_buffer_full) ? IO_WAIT : XFER;
         rr_d    = (int'(gnt_port) == NUM_PORTS - 1) ? '0 : gnt_port + 1'b1;
         port_d  = gnt_port;
         addr_d  = sel_addr;
         wdata_d = req_wdata[int'(gnt_port)*DATA_WIDTH +: DATA_WIDTH];
         id_d    = req_id[int'(gnt_port)*ID_WIDTH +: ID_WIDTH];
         write_d = req_write[gnt_port];
         len_d   = size_len(sel_size);
         cnt_d   = '0;
         data_d  = '0;
`ifdef MPMC_RVC_FETCH_EN
         fetch_d = (sel_size == 2'd3) & ~req_write[gnt_port];
         uns_d   = req_unsigned[gnt_port] | fetch_d;
`else
         uns_d   = req_unsigned[gnt_port];
`endif
      end
   end

   always_comb begin
      ram_addr = '0;
      ram_dout = '0;
      ram_wr   = 1'b0;
      if (issue) begin
         ram_addr = addr_q + ADDR_WIDTH'(cnt_q);
         ram_wr   = write_q & rdy;
         for (int b = 0; b < NB; b++)
            if (write_q && cnt_q == CW'(b)) ram_dout = wdata_q[8*b +: 8];
      end
   end

   assign resp_valid = (state_q == RESP && rdy) ? (NUM_PORTS'(1) << port_q) : '0;
   assign resp_data  = (state_q == RESP && rdy) ? extend(data_q, len_q, uns_q) : '0;
   assign resp_id    = (state_q == RESP && rdy) ? id_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         port_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         data_q    <= '0;
         id_q      <= '0;
         write_q   <= 1'b0;
         uns_q     <= 1'b0;
         len_q     <= '0;
         cnt_q     <= '0;
         iss_vld_q <= 1'b0;
         iss_idx_q <= '0;
`ifdef MPMC_RVC_FETCH_EN
         fetch_q   <= 1'b0;
`endif
      end else begin
         // The RAM returns data one cycle after an address regardless of rdy, so capture is not frozen.
         iss_vld_q <= issue & rdy & ~write_q;
         iss_idx_q <= cnt_q;
         if (rdy) begin
            state_q <= state_d;
            rr_q    <= rr_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            id_q    <= id_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef MPMC_RVC_FETCH_EN
            fetch_q <= fetch_d;
`endif
         end
         for (int b = 0; b < NB; b++)
            if (iss_vld_q && iss_idx_q == CW'(b)) data_q[8*b +: 8] <= ram_din;
`ifdef MPMC_RVC_FETCH_EN
         if (fetch_q && iss_vld_q && iss_idx_q == '0 && ram_din[1:0] != 2'b11) len_q <= CW'(2);
`endif
      end
   end
endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// Directed bench for multi_port_mem_ctrl: vector table of single transactions plus hand-written corner sequences.
module tb_multi_port_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst, rdy, flush, io_buffer_full;
   logic [1:0]  req_valid, req_ready, req_write, req_unsigned, resp_valid;
   logic [3:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_id;
   logic [31:0] resp_data;
   logic [3:0]  resp_id;
   logic        busy;
   logic [7:0]  ram_din, ram_dout;
   logic [31:0] ram_addr;
   logic        ram_wr;

   multi_port_mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id), .busy(busy),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [0:262143];
   logic        pl_en = 1'b0;
   logic [17:0] pl_a;
   logic [7:0]  pl_d;
   always @(posedge clk) begin
      if (pl_en) mem[pl_a] <= pl_d;
      else if (ram_wr) mem[ram_addr[17:0]] <= ram_dout;
      ram_din <= mem[ram_addr[17:0]];
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [39:0] wr_tr, busy_tr, zr_tr;
   logic [31:0] addr_tr [0:39];
   int          rc;
   logic [31:0] rd;
   logic [3:0]  rid;

   typedef struct {
      int          port;
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  id;
      logic [31:0] exp_d;
      int          exp_lat;
   } vec_t;
   localparam int NV = 11;
   vec_t vt [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [17:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One request; cycle 0 is the accept cycle, traces are sampled at the falling edge of cycles 1..39.
   task automatic run_req(input int p, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] id,
                          input int fl_cyc, input int full_cyc, input int rlo_s, input int rlo_n,
                          input int rst_cyc);
      int c;
      rc = -1; rd = '0; rid = '0; wr_tr = '0; busy_tr = '0; zr_tr = '0;
      for (int k = 0; k < 40; k++) addr_tr[k] = '0;
      @(negedge clk);
      req_valid = '0;
      req_valid[p] = 1'b1;
      req_write[p] = w;
      req_size[2*p +: 2] = sz;
      req_unsigned[p] = u;
      req_addr[32*p +: 32] = a;
      req_wdata[32*p +: 32] = wd;
      req_id[4*p +: 4] = id;
      io_buffer_full = (full_cyc > 0);
      #1;
      c = 0;
      while (!req_ready[p] && c < 20) begin
         @(negedge clk); #1;
         c++;
      end
      if (!req_ready[p]) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: port %0d req_ready %b required grant", p, req_ready);
         req_valid = '0;
         return;
      end
      @(posedge clk); #1;
      req_valid = '0;
      for (int k = 1; k < 40; k++) begin
         flush = (k == fl_cyc);
         io_buffer_full = (k < full_cyc);
         rdy = !(k >= rlo_s && k < rlo_s + rlo_n);
         rst = (k == rst_cyc);
         @(negedge clk);
         wr_tr[k] = ram_wr;
         busy_tr[k] = busy;
         addr_tr[k] = ram_addr;
         zr_tr[k] = (!busy && !ram_wr && ram_addr == 0 && ram_dout == 0 && resp_valid == 0 &&
                     resp_data == 0 && resp_id == 0 && req_ready == 0);
         if (resp_valid[p] && rc < 0) begin
            rc = k; rd = resp_data; rid = resp_id;
         end
         @(posedge clk); #1;
      end
      flush = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1; rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g_p[$], g_c[$], r_p[$], r_c[$];
      logic [31:0] r_d[$];
      int multi, n2;

      rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      req_valid = '0; req_write = '0; req_size = '0; req_unsigned = '0;
      req_addr = '0; req_wdata = '0; req_id = '0;

      poke(18'h100, 8'h80);
      poke(18'h200, 8'h34); poke(18'h201, 8'h92);
      poke(18'h300, 8'h78); poke(18'h301, 8'h56); poke(18'h302, 8'h34); poke(18'h303, 8'h12);
      poke(18'h3FFFE, 8'hAA); poke(18'h3FFFF, 8'hBB);
      poke(18'h0, 8'h01); poke(18'h1, 8'h45);
      poke(18'h10, 8'h13); poke(18'h11, 8'h05); poke(18'h12, 8'h00); poke(18'h13, 8'h00);
      do_reset();

      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_ram_addr", ram_addr, 32'h0);
      chk("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
      chk("rst_resp_valid", {30'b0, resp_valid}, 32'h0);
      chk("rst_resp_data", resp_data, 32'h0);

      // Both ports stream word loads from a fresh reset.
      @(negedge clk);
      req_valid = 2'b11; req_write = 2'b00; req_size = 4'b1010; req_unsigned = 2'b00;
      req_addr = {32'h300, 32'h300}; req_id = {4'hB, 4'hA};
      #1;
      multi = 0;
      for (int cyc = 0; cyc < 26; cyc++) begin
         if ($countones(req_ready) > 1) multi++;
         if (req_ready[0]) begin g_p.push_back(0); g_c.push_back(cyc); end
         else if (req_ready[1]) begin g_p.push_back(1); g_c.push_back(cyc); end
         if (resp_valid[0]) begin r_p.push_back(0); r_c.push_back(cyc); r_d.push_back(resp_data); end
         else if (resp_valid[1]) begin r_p.push_back(1); r_c.push_back(cyc); r_d.push_back(resp_data); end
         @(posedge clk); #1;
      end
      req_valid = '0;
      repeat (10) @(posedge clk);
      #1;
      chk("rr_multi_grant", 32'(multi), 32'd0);
      chk("rr_grant_count", 32'(g_p.size()), 32'd5);
      chk("rr_resp_count", 32'(r_p.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_grant%0d_port", i), 32'(g_p[i]), 32'(i % 2));
         chk($sformatf("rr_grant%0d_cycle", i), 32'(g_c[i]), 32'(6 * i));
         chk($sformatf("rr_resp%0d_port", i), 32'(r_p[i]), 32'(i % 2));
         chk($sformatf("rr_resp%0d_cycle", i), 32'(r_c[i]), 32'(6 * i + 6));
      end
      chk("rr_resp_data", r_d[0], 32'h12345678);

      vt[0]  = '{1, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 4'd1, 32'hFFFFFF80, 3};
      vt[1]  = '{1, 1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 4'd2, 32'h00000080, 3};
      vt[2]  = '{0, 1'b0, 2'd1, 1'b0, 32'h200, 32'h0, 4'd3, 32'hFFFF9234, 4};
      vt[3]  = '{0, 1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 4'd4, 32'h00009234, 4};
      vt[4]  = '{1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 4'd5, 32'h12345678, 6};
      vt[5]  = '{0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hA1B2C3D4, 4'd6, 32'h0, 5};
      vt[6]  = '{0, 1'b0, 2'd0, 1'b0, 32'h402, 32'h0, 4'd7, 32'hFFFFFFB2, 3};
      vt[7]  = '{1, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 4'd8, 32'h4501BBAA, 6};
`ifdef MPMC_RVC_FETCH_EN
      vt[8]  = '{0, 1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 4'd9, 32'h00005678, 4};
`else
      vt[8]  = '{0, 1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 4'd9, 32'h12345678, 6};
`endif
      vt[9]  = '{1, 1'b1, 2'd0, 1'b0, 32'h404, 32'h00000077, 4'd11, 32'h0, 2};
      vt[10] = '{1, 1'b0, 2'd0, 1'b1, 32'h301, 32'h0, 4'd12, 32'h00000056, 3};

      for (int i = 0; i < NV; i++) begin
         run_req(vt[i].port, vt[i].w, vt[i].sz, vt[i].u, vt[i].addr, vt[i].wd, vt[i].id, -1, 0, 0, 0, -1);
         chk($sformatf("v%0d_data", i), rd, vt[i].exp_d);
         chk($sformatf("v%0d_latency", i), 32'(rc), 32'(vt[i].exp_lat));
         chk($sformatf("v%0d_id", i), {28'b0, rid}, {28'b0, vt[i].id});
      end
      chk("sw_mem_0x400", {24'b0, mem[18'h400]}, 32'hD4);
      chk("sw_mem_0x403", {24'b0, mem[18'h403]}, 32'hA1);
      chk("sb_mem_0x404", {24'b0, mem[18'h404]}, 32'h77);

      // Flush filter at accept: masked load refused, store on the other port granted.
      @(negedge clk);
      req_valid = 2'b11; req_write = 2'b10; req_size = 4'b1010; flush = 1'b1;
      #1;
      chk("flush_accept_filter", {30'b0, req_ready}, 32'h2);
      req_valid = '0; req_write = '0; flush = 1'b0;

      // IO store held while the IO buffer is full for 3 cycles.
      run_req(1, 1'b1, 2'd2, 1'b0, 32'h30004, 32'hDEADBEEF, 4'd3, -1, 3, 0, 0, -1);
      chk("io_wait_no_wr", {29'b0, wr_tr[3:1]}, 32'h0);
      chk("io_wr_window", {27'b0, wr_tr[8:4]}, 32'h0F);
      chk("io_resp_cycle", 32'(rc), 32'd8);
      chk("io_first_addr", addr_tr[4], 32'h30004);
      chk("io_last_addr", addr_tr[7], 32'h30007);
      chk("io_mem", {mem[18'h30007], mem[18'h30006], mem[18'h30005], mem[18'h30004]}, 32'hDEADBEEF);

      // Flushed load is dropped; flushed store completes.
      run_req(0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 4'd1, 2, 0, 0, 0, -1);
      chk("flush_lw_no_resp", 32'(rc), 32'hFFFFFFFF);
      chk("flush_lw_busy_c2", {31'b0, busy_tr[2]}, 32'h1);
      chk("flush_lw_idle_c3", {31'b0, busy_tr[3]}, 32'h0);
      run_req(0, 1'b1, 2'd1, 1'b0, 32'h500, 32'h1234CAFE, 4'd2, 1, 0, 0, 0, -1);
      chk("flush_sh_wr", {29'b0, wr_tr[3:1]}, 32'h3);
      chk("flush_sh_resp", 32'(rc), 32'd3);
      chk("flush_sh_mem", {16'b0, mem[18'h501], mem[18'h500]}, 32'h0000CAFE);

      // rdy low for 5 cycles in the middle of a load, then 3 cycles in a store.
      run_req(1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 4'd4, -1, 0, 2, 5, -1);
      chk("rdy_lw_resp", 32'(rc), 32'd11);
      chk("rdy_lw_data", rd, 32'h12345678);
      chk("rdy_lw_addr_c2", addr_tr[2], 32'h301);
      chk("rdy_lw_addr_c6", addr_tr[6], 32'h301);
      run_req(0, 1'b1, 2'd2, 1'b0, 32'h600, 32'h11223344, 4'd5, -1, 0, 2, 3, -1);
      chk("rdy_sw_wr", {24'b0, wr_tr[8:1]}, 32'h71);
      chk("rdy_sw_resp", 32'(rc), 32'd8);
      chk("rdy_sw_mem", {mem[18'h603], mem[18'h602], mem[18'h601], mem[18'h600]}, 32'h11223344);

      // Synchronous reset in the middle of a load.
      run_req(0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 4'd6, -1, 0, 0, 0, 2);
      chk("rst_mid_busy_c2", {31'b0, busy_tr[2]}, 32'h1);
      chk("rst_mid_zero_c3", {31'b0, zr_tr[3]}, 32'h1);
      chk("rst_mid_no_resp", 32'(rc), 32'hFFFFFFFF);

`ifdef MPMC_RVC_FETCH_EN
      run_req(0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 4'd7, -1, 0, 0, 0, -1);
      chk("fetch16_data", rd, 32'h00004501);
      chk("fetch16_resp", 32'(rc), 32'd4);
      n2 = 0;
      for (int k = 1; k < 10; k++) if (addr_tr[k] == 32'h2) n2++;
      chk("fetch16_no_addr2", 32'(n2), 32'd0);
      run_req(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 4'd8, -1, 0, 0, 0, -1);
      chk("fetch32_data", rd, 32'h00000513);
      chk("fetch32_resp", 32'(rc), 32'd6);
`else
      n2 = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multi_port_mem_ctrl.md
# multi_port_mem_ctrl

Parametrised successor to the single-fetch/single-LSB memory controller. It arbitrates NUM_PORTS requesters round-robin onto the byte-serial RAM bus. It performs byte/half/word loads and stores with sign/zero extension, holds memory-mapped IO accesses while the IO buffer is full, and cancels in-flight loads on pipeline flush. It sits between the fetcher/LSB (and any future requesters) and the RAM/IO bus.

## Interface
Parameters:
- NUM_PORTS, 2: requester count; port 0 has the highest priority only at reset.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; NB = DATA_WIDTH/8 bytes max per access.
- ID_WIDTH, 4: request tag width.
- IO_BASE, 'h30000: start of the IO window; the window covers IO_BASE..IO_BASE+7.
- FLUSH_MASK, all ones: bit p=1 means flush cancels port p loads.

Ports (vectors are port-major, so port p occupies slice p):
- clk, in, 1: clock. Reset rst, synchronous, active-high; clock clk.
- rst, in, 1: synchronous active-high reset.
- rdy, in, 1: global enable; when 0 all state freezes.
- flush, in, 1: pipeline flush.
- io_buffer_full, in, 1: IO sink cannot accept.
- req_valid, in, NUM_PORTS: request present.
- req_ready, out, NUM_PORTS: one-hot grant (combinational).
- req_write, in, NUM_PORTS: 1 = store.
- req_size, in, 2*NUM_PORTS: 0 = byte, 1 = half, 2 = word, 3 = fetch.
- req_unsigned, in, NUM_PORTS: zero-extend load.
- req_addr, in, ADDR_WIDTH*NUM_PORTS: request address.
- req_wdata, in, DATA_WIDTH*NUM_PORTS: store data.
- req_id, in, ID_WIDTH*NUM_PORTS: request tag.
- resp_valid, out, NUM_PORTS: one-cycle completion pulse.
- resp_data, out, DATA_WIDTH: load result; 0 when no resp_valid.
- resp_id, out, ID_WIDTH: tag of the completing request.
- busy, out, 1: FSM not IDLE.
- ram_din, in, 8: RAM read byte; valid 1 cycle after its address.
- ram_dout, out, 8: write byte.
- ram_addr, out, ADDR_WIDTH: RAM address.
- ram_wr, out, 1: write strobe.

## Operation
- FSM states: IDLE, XFER, IO_WAIT, RESP.
- IDLE: req_ready is one-hot to the first valid port at or after rr_ptr (wrapping), gated by rdy. During flush, a port masked in FLUSH_MASK is granted only if it is a store. Accepting a request latches addr/size/data/id/port and sets rr_ptr = port+1 mod NUM_PORTS.
- IO detection on accept: addr within the IO window and io_buffer_full gives IO_WAIT; otherwise XFER.
- IO_WAIT: ram_wr=0, ram_addr=0. Leaves for XFER the first cycle io_buffer_full=0.
- XFER: issues byte i at addr+i (wraps modulo 2^ADDR_WIDTH, no alignment rule), i = 0..len-1, len = 1/2/NB for size 0/1/2. A size exceeding NB clamps to NB. A store drives ram_dout = wdata[8i+7:8i] with ram_wr=1. A load captures ram_din into byte i one cycle later.
- Load result: bytes assembled little-endian, then sign-extended from bit 8*len-1 unless req_unsigned.
- RESP: resp_valid[port]=1 and resp_id for one cycle; ram_wr=0, ram_addr=0; FSM returns to IDLE in the same cycle, so req_ready may be asserted then.
- Flush during XFER/IO_WAIT of a FLUSH_MASK load: abort at the next edge, no response, go to IDLE, ram_addr=0. Stores and unmasked ports always complete.
- rdy=0: state and registers hold, and ram_wr is masked to 0.
- rst: all registers and outputs 0, rr_ptr=0, state IDLE.

## Timing
- Cycle 0 is the accept cycle (valid & ready).
- Cycles 1..len: ram_addr=addr+i. The load's last byte arrives in cycle len+1; resp_valid for the load is in cycle len+2.
- A store has ram_wr high in cycles 1..len; resp_valid comes in cycle len+1.
- IO_WAIT inserts k cycles before cycle 1, one per cycle io_buffer_full is high.
- Throughput: next accept possible in the RESP cycle; no pipelining of two requests.
- Simultaneous flush and accept: the flush filter applies first. A load accepted on a non-masked port is unaffected.

## Configuration
- MPMC_RVC_FETCH_EN defined: size 3 is fetch mode. Byte 0 arrives in cycle 2. If ram_din[1:0] != 2'b11 then len=2: no address issued in cycle 3, resp_valid in cycle 4, and data is zero-extended to 16 bits. Otherwise len=4 and resp_valid is in cycle 6, unsigned.
- MPMC_RVC_FETCH_EN undefined: size 3 is treated as size 2 (word, signed per req_unsigned).

## Test plan
- Port 1 LB addr 0x100, RAM[0x100]=0x80, signed: resp_data=0xFFFFFF80 in cycle 3. The same access with unsigned gives 0x00000080.
- Both ports request word loads continuously: grants alternate 0,1,0,1; each resp_valid is 6 cycles after its accept; no cycle with two req_ready bits.
- SW 0xDEADBEEF to IO_BASE+4 with io_buffer_full high 3 cycles: ram_wr=0 for 3 cycles. Then bytes EF,BE,AD,DE go to addresses 0x30004..0x30007, and resp_valid follows.
- LW accepted, flush asserted in cycle 2: no resp_valid, busy=0 next cycle. An SH flushed mid-transfer still writes both bytes and acks.
- With MPMC_RVC_FETCH_EN, fetch at 0x0 with RAM 0x01,0x45: resp_data=0x4501 in cycle 4, ram_addr never 0x2. RAM 0x13,0x05,0x00,0x00 gives 0x00000513 in cycle 6.
- rdy dropped for 5 cycles mid-LW: outputs frozen, ram_wr=0, and the result is identical once rdy returns. rst mid-transfer gives all outputs 0 next cycle.
